conv_mac_sequencer: RTL and testbench
=====================================

// Module: conv_mac_sequencer
// PURPOSE
//  Job controller for the 4-lane conv MAC datapath. Buffers one image vector and one kernel
//  vector via valid/ready streams, then issues NUM_LANES operand pairs to the shared MAC/PE
//  array one per cycle. It captures the accumulated partial sum, saturates it to DATA_W, and
//  returns it on a valid/ready result port. It also drives the red/blue/green stage LEDs.
// PARAMETERS
//  NUM_LANES  4   operand pairs per job; buffer depth (power of 2, >=2)
//  DATA_W     8   activation / weight / result width
//  ACC_W      32  width of pe_psum returned by the MAC array
//  PE_LAT     1   cycles from the last pe_en cycle until pe_psum holds the final sum (>=1)
// PORTS
//  clk        in   1        clock, rising edge
//  reset_n    in   1        asynchronous, active-low reset
//  start      in   1        job request; sampled only in IDLE/OUTPUT (see below)
//  abort      in   1        synchronous job cancel
//  busy       out  1        high whenever state != IDLE
//  img_valid  in   1        image beat valid
//  img_ready  out  1        high in LOAD_IMG
//  img_data   in   DATA_W   image element, lane order 0..NUM_LANES-1
//  ker_valid  in   1        kernel beat valid
//  ker_ready  out  1        high in LOAD_KER
//  ker_data   in   DATA_W   kernel element, lane order 0..NUM_LANES-1
//  pe_en      out  1        operand pair valid to MAC array
//  pe_clr     out  1        clear accumulator; coincident with lane-0 pe_en
//  pe_lane    out  log2(NUM_LANES)  lane index of current pair
//  pe_act     out  DATA_W   activation operand
//  pe_wgt     out  DATA_W   weight operand
//  pe_psum    in   ACC_W    accumulated sum from MAC array, unsigned
//  res_valid  out  1        result valid; held until res_ready
//  res_ready  in   1        result accepted when res_valid && res_ready
//  res_data   out  DATA_W   saturated result
//  LED_RED / LED_BLUE / LED_GREEN  out 1 each  stage indicators
// BEHAVIOUR
//  - reset_n low: state=IDLE, counters/buffers=0, every output 0 immediately (async), LEDs off.
//  - All outputs registered; img_ready/ker_ready/busy/LEDs decoded from the state register only.
//  - FSM IDLE -> LOAD_IMG -> LOAD_KER -> COMPUTE -> DRAIN -> OUTPUT -> IDLE.
//  - IDLE: start=1 -> LOAD_IMG, cnt=0. LEDs off.
//  - LOAD_IMG (RED): each img_valid&&img_ready writes img_buf[cnt] and increments cnt.
//    After the NUM_LANES-th beat: -> LOAD_KER, cnt=0. Gaps in img_valid just stall.
//  - LOAD_KER (BLUE): same rule into ker_buf; after the last beat -> COMPUTE, cnt=0.
//  - COMPUTE (GREEN): exactly NUM_LANES consecutive cycles with pe_en=1,
//    pe_lane=cnt, pe_act=img_buf[cnt], pe_wgt=ker_buf[cnt]; pe_clr=1 only when cnt=0.
//    The array has no backpressure. Then -> DRAIN.
//  - DRAIN (GREEN): PE_LAT cycles, pe_en=0. On the last DRAIN edge,
//    res_data<=(pe_psum>2^DATA_W-1)?2^DATA_W-1:pe_psum[DATA_W-1:0] and res_valid<=1. -> OUTPUT.
//  - OUTPUT (GREEN): res_data held stable while res_valid && !res_ready.
//    On the handshake, res_valid<=0 and the FSM goes to LOAD_IMG if start=1 in that same
//    cycle, otherwise to IDLE.
//  - start in any other state is ignored (not queued).
//  - abort=1 in any non-IDLE state: next edge -> IDLE, pe_en/pe_clr/res_valid <= 0,
//    partial buffers discarded; abort has priority over start and over handshakes.
//  - Latency with no stalls: start edge -> NUM_LANES img beats + NUM_LANES ker beats
//    + NUM_LANES compute cycles + PE_LAT -> res_valid.
//  - Buffers are overwritten each job; a partial load never leaks into a later job.
// TESTING (bench MAC model: psum+=act*wgt, cleared by pe_clr, PE_LAT=1)
//  1 img 1,2,3,4; ker 1,2,3,4; res_ready=1 -> res_data=30.
//    pe_en high exactly 4 cycles; pe_clr exactly once; LEDs R->B->G in order.
//  2 img 255x4; ker 255x4 -> psum 260100 -> res_data=255 (saturated).
//  3 img_valid every other cycle; res_ready low 5 cycles -> same result 30;
//    res_data/res_valid stable while stalled; start pulsed in LOAD_KER is ignored.
//  4 abort after 2 COMPUTE cycles -> IDLE next cycle; pe_en=0; no res_valid.
//    Next job (img 2,2,2,2; ker 3,3,3,3) -> 24.
//  5 reset_n low during LOAD_KER -> all outputs 0 asynchronously.
//    After release, job 1 stimulus -> 30.
//  6 start=1 in the res handshake cycle -> next cycle is LOAD_IMG (img_ready=1, LED_RED=1);
//    back-to-back jobs both correct.

Source files
------------

// File: rtl/conv_mac_sequencer.sv
// Job controller for the conv MAC datapath: buffers one image and one kernel vector,
// streams operand pairs to the MAC array, then returns the saturated partial sum.
module conv_mac_sequencer #(
   parameter int NUM_LANES = 4,
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 32,
   parameter int PE_LAT    = 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         abort,
   output logic                         busy,
   input  logic                         img_valid,
   output logic                         img_ready,
   input  logic [DATA_W-1:0]            img_data,
   input  logic                         ker_valid,
   output logic                         ker_ready,
   input  logic [DATA_W-1:0]            ker_data,
   output logic                         pe_en,
   output logic                         pe_clr,
   output logic [$clog2(NUM_LANES)-1:0] pe_lane,
   output logic [DATA_W-1:0]            pe_act,
   output logic [DATA_W-1:0]            pe_wgt,
   input  logic [ACC_W-1:0]             pe_psum,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [DATA_W-1:0]            res_data,
   output logic                         LED_RED,
   output logic                         LED_BLUE,
   output logic                         LED_GREEN
);

   localparam int LANE_W  = $clog2(NUM_LANES);
   localparam int CNT_MAX = (NUM_LANES > PE_LAT) ? NUM_LANES : PE_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] LAST_LANE  = CNT_W'(NUM_LANES - 1);
   localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(PE_LAT - 1);
   localparam logic [ACC_W-1:0] SAT_MAX    = ACC_W'({DATA_W{1'b1}});

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_IMG,
      S_LOAD_KER,
      S_COMPUTE,
      S_DRAIN,
      S_OUTPUT
   } state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [LANE_W-1:0] lane_q, lane_d;

   logic [DATA_W-1:0] img_buf [NUM_LANES];
   logic [DATA_W-1:0] ker_buf [NUM_LANES];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD_IMG;
               cnt_d   = '0;
            end
         end
         S_LOAD_IMG: begin
            if (img_valid) begin
               if (cnt == LAST_LANE) begin
                  state_d = S_LOAD_KER;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
         S_LOAD_KER: begin
            if (ker_valid) begin
               if (cnt == LAST_LANE) begin
                  state_d = S_COMPUTE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
         end
         S_COMPUTE: begin
            if (cnt == LAST_LANE) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt == LAST_DRAIN) begin
               state_d = S_OUTPUT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         S_OUTPUT: begin
            // res_valid is always high here, so res_ready alone completes the handshake
            if (res_ready) begin
               state_d = start ? S_LOAD_IMG : S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (abort && (state != S_IDLE)) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   always_comb begin
      busy      = (state != S_IDLE);
      img_ready = (state == S_LOAD_IMG);
      ker_ready = (state == S_LOAD_KER);
      LED_RED   = (state == S_LOAD_IMG);
      LED_BLUE  = (state == S_LOAD_KER);
      LED_GREEN = (state == S_COMPUTE) || (state == S_DRAIN) || (state == S_OUTPUT);
   end

   assign lane_q = cnt[LANE_W-1:0];
   assign lane_d = cnt_d[LANE_W-1:0];

   // Operand outputs are registered from the next-state values so they line up with COMPUTE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         img_buf   <= '{default: '0};
         ker_buf   <= '{default: '0};
         pe_en     <= 1'b0;
         pe_clr    <= 1'b0;
         pe_lane   <= '0;
         pe_act    <= '0;
         pe_wgt    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
      end else begin
         if ((state == S_LOAD_IMG) && img_valid) begin
            img_buf[lane_q] <= img_data;
         end
         if ((state == S_LOAD_KER) && ker_valid) begin
            ker_buf[lane_q] <= ker_data;
         end

         if (state_d == S_COMPUTE) begin
            pe_en   <= 1'b1;
            pe_clr  <= (cnt_d == '0);
            pe_lane <= lane_d;
            pe_act  <= img_buf[lane_d];
            pe_wgt  <= ker_buf[lane_d];
         end else begin
            pe_en   <= 1'b0;
            pe_clr  <= 1'b0;
            pe_lane <= '0;
            pe_act  <= '0;
            pe_wgt  <= '0;
         end

         if ((state == S_DRAIN) && (state_d == S_OUTPUT)) begin
            res_valid <= 1'b1;
            res_data  <= (pe_psum > SAT_MAX) ? SAT_MAX[DATA_W-1:0] : pe_psum[DATA_W-1:0];
         end else if ((state == S_OUTPUT) && (state_d != S_OUTPUT)) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Self-checking bench for conv_mac_sequencer with a behavioural MAC array (PE_LAT=1).
module tb_conv_mac_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0;
   logic        img_valid = 1'b0, ker_valid = 1'b0, res_ready = 1'b0;
   logic [7:0]  img_data = '0, ker_data = '0;
   logic        busy, img_ready, ker_ready, pe_en, pe_clr, res_valid;
   logic        LED_RED, LED_BLUE, LED_GREEN;
   logic [1:0]  pe_lane;
   logic [7:0]  pe_act, pe_wgt, res_data;
   logic [31:0] pe_psum = '0;
   logic [34:0] all_out;

   int checks = 0, failures = 0;
   int pe_en_seen = 0, pe_clr_seen = 0, lane_bad = 0, last_lane = 0;
   int pe_en_base = 0, pe_clr_base = 0, lane_bad_base = 0;

   typedef struct packed {
      logic [3:0][7:0] img;
      logic [3:0][7:0] ker;
      logic            gap;
      logic [3:0]      stall;
      logic            sk;
      logic [7:0]      exp;
   } vec_t;

   vec_t tbl[8];

   conv_mac_sequencer #(.NUM_LANES(4), .DATA_W(8), .ACC_W(32), .PE_LAT(1)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .busy(busy),
      .img_valid(img_valid), .img_ready(img_ready), .img_data(img_data),
      .ker_valid(ker_valid), .ker_ready(ker_ready), .ker_data(ker_data),
      .pe_en(pe_en), .pe_clr(pe_clr), .pe_lane(pe_lane), .pe_act(pe_act), .pe_wgt(pe_wgt),
      .pe_psum(pe_psum), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .LED_RED(LED_RED), .LED_BLUE(LED_BLUE), .LED_GREEN(LED_GREEN)
   );

   assign all_out = {busy, img_ready, ker_ready, pe_en, pe_clr, pe_lane, pe_act, pe_wgt,
                     res_valid, res_data, LED_RED, LED_BLUE, LED_GREEN};

   always #5 clk = ~clk;

   // MAC array model
   always @(posedge clk) begin
      if (pe_en) pe_psum <= (pe_clr ? 32'd0 : pe_psum) + 32'(pe_act) * 32'(pe_wgt);
   end

   always @(negedge clk) begin
      if (pe_en) begin
         pe_en_seen++;
         if (pe_clr) pe_clr_seen++;
         if (pe_clr ? (pe_lane != 2'd0) : (int'(pe_lane) != last_lane + 1)) lane_bad++;
         last_lane = int'(pe_lane);
      end
   end

   function automatic logic [7:0] ref_result(input logic [3:0][7:0] a, input logic [3:0][7:0] b);
      longint sum = 0;
      for (int i = 0; i < 4; i++) sum += longint'(a[i]) * longint'(b[i]);
      return (sum > 255) ? 8'd255 : sum[7:0];
   endfunction

   function automatic vec_t mk(input logic [31:0] img, input logic [31:0] ker, input bit gap,
                               input logic [3:0] stall, input bit sk, input logic [7:0] exp);
      vec_t v;
      v.img = img; v.ker = ker; v.gap = gap; v.stall = stall; v.sk = sk; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic start_job();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load_img(input logic [3:0][7:0] img, input bit gap);
      int n;
      pe_en_base = pe_en_seen; pe_clr_base = pe_clr_seen; lane_bad_base = lane_bad;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!img_ready && n < 50) begin @(negedge clk); n++; end
         check("img_ready", img_ready, 1);
         if (i == 0) check("led_red", {LED_RED, LED_BLUE, LED_GREEN}, 3'b100);
         img_valid = 1'b1; img_data = img[i];
         @(negedge clk);
         img_valid = 1'b0; img_data = '0;
         if (gap) @(negedge clk);
      end
   endtask

   task automatic load_ker(input logic [3:0][7:0] ker, input bit gap, input bit start_pulse);
      int n;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!ker_ready && n < 50) begin @(negedge clk); n++; end
         check("ker_ready", ker_ready, 1);
         if (i == 0) check("led_blue", {LED_RED, LED_BLUE, LED_GREEN}, 3'b010);
         ker_valid = 1'b1; ker_data = ker[i];
         start = start_pulse && (i == 1);
         @(negedge clk);
         ker_valid = 1'b0; ker_data = '0; start = 1'b0;
         if (gap) @(negedge clk);
      end
   endtask

   task automatic finish_job(input int stall, input bit start_at_hs, input logic [7:0] exp);
      int n = 0;
      logic [7:0] held;
      bit stable = 1'b1;
      while (!res_valid && n < 40) begin @(negedge clk); n++; end
      check("res_valid_rise", res_valid, 1);
      check("led_green", {LED_RED, LED_BLUE, LED_GREEN}, 3'b001);
      held = res_data;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (!res_valid || res_data !== held) stable = 1'b0;
      end
      if (stall > 0) check("res_stable", stable, 1);
      check("res_data", res_data, exp);
      check("pe_en_cycles", pe_en_seen - pe_en_base, 4);
      check("pe_clr_count", pe_clr_seen - pe_clr_base, 1);
      check("pe_lane_seq", lane_bad - lane_bad_base, 0);
      res_ready = 1'b1; start = start_at_hs;
      @(negedge clk);
      res_ready = 1'b0; start = 1'b0;
      check("res_valid_drop", res_valid, 0);
      if (start_at_hs) check("restart_load_img", {img_ready, LED_RED}, 2'b11);
      else             check("idle_after_job", busy, 0);
   endtask

   initial begin
      logic [3:0][7:0] ri, rk;
      bit              rv_seen;
      int              lim;

      tbl[0] = mk(32'h04030201, 32'h04030201, 1'b0, 4'd0, 1'b0, 8'd30);
      tbl[1] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd0, 1'b0, 8'd255);
      tbl[2] = mk(32'h04030201, 32'h04030201, 1'b1, 4'd5, 1'b1, 8'd30);
      tbl[3] = mk(32'h02020202, 32'h03030303, 1'b0, 4'd1, 1'b0, 8'd24);
      tbl[4] = mk(32'h0000000A, 32'h00000019, 1'b0, 4'd0, 1'b0, 8'd250);
      tbl[5] = mk(32'h00000010, 32'h00000010, 1'b1, 4'd2, 1'b0, 8'd255);
      tbl[6] = mk(32'h0000000F, 32'h00000011, 1'b0, 4'd0, 1'b0, 8'd255);
      tbl[7] = mk(32'h00000000, 32'h05050505, 1'b0, 4'd0, 1'b0, 8'd0);

      repeat (2) @(negedge clk);
      check("reset_outputs", all_out, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("idle_not_busy", busy, 0);

      for (int t = 0; t < 8; t++) begin
         start_job();
         load_img(tbl[t].img, tbl[t].gap);
         load_ker(tbl[t].ker, tbl[t].gap, tbl[t].sk);
         finish_job(int'(tbl[t].stall), 1'b0, tbl[t].exp);
      end

      // abort after two compute cycles
      start_job();
      load_img(32'h04030201, 1'b0);
      load_ker(32'h04030201, 1'b0, 1'b0);
      @(negedge clk);
      check("pe_en_pre_abort", pe_en, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", {busy, pe_en, pe_clr, res_valid}, 0);
      rv_seen = 1'b0;
      repeat (8) begin @(negedge clk); if (res_valid) rv_seen = 1'b1; end
      check("no_result_after_abort", rv_seen, 0);
      start_job();
      load_img(32'h02020202, 1'b0);
      load_ker(32'h03030303, 1'b0, 1'b0);
      finish_job(0, 1'b0, 8'd24);

      // asynchronous reset in the middle of the kernel load
      start_job();
      load_img(32'h04030201, 1'b0);
      ker_valid = 1'b1; ker_data = 8'd9;
      repeat (2) @(negedge clk);
      ker_valid = 1'b0; ker_data = '0;
      check("busy_before_reset", {busy, ker_ready, LED_BLUE}, 3'b111);
      #2 reset_n = 1'b0;
      #1 check("async_reset_outputs", all_out, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      start_job();
      load_img(32'h04030201, 1'b0);
      load_ker(32'h04030201, 1'b0, 1'b0);
      finish_job(0, 1'b0, 8'd30);

      // start in the handshake cycle chains straight into the next load
      start_job();
      load_img(32'h04030201, 1'b0);
      load_ker(32'h04030201, 1'b0, 1'b0);
      finish_job(2, 1'b1, 8'd30);
      ri = 32'h0A0B0C0D; rk = 32'h01020304;
      load_img(ri, 1'b0);
      load_ker(rk, 1'b0, 1'b0);
      finish_job(0, 1'b0, ref_result(ri, rk));

      for (int j = 0; j < 20; j++) begin
         lim = $urandom_range(0, 1) ? 255 : 12;
         for (int i = 0; i < 4; i++) begin
            ri[i] = 8'($urandom_range(0, lim));
            rk[i] = 8'($urandom_range(0, lim));
         end
         start_job();
         load_img(ri, 1'($urandom_range(0, 1)));
         load_ker(rk, 1'($urandom_range(0, 1)), 1'b0);
         finish_job(int'($urandom_range(0, 3)), 1'b0, ref_result(ri, rk));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
